manchester_frame_arbiter: RTL and testbench
===========================================

MANCHESTER_FRAME_ARBITER -- requirements
Module: manchester_frame_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte lane width of all stream ports.
REQ-002 Parameter IDLE_GAP, default 2, minimum number of idle cycles the master port SHALL hold between frames (legal range 0..15).
REQ-003 aclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 areset  input  1  synchronous, active-high reset.
REQ-005 s0_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  requester 0 frame stream.
REQ-006 s1_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  requester 1 frame stream.
REQ-007 m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  stream to the Manchester escape encoder.
REQ-008 grant  output  2  one-hot owner of the master port: 01 = port 0, 10 = port 1, 00 = none.
REQ-009 frame_cnt0, frame_cnt1  output  16 each  completed-frame counters, one per requester.

Function
REQ-010 The block SHALL share one encoder between two requesters at frame granularity: a grant is held from the first beat until the tlast beat of a frame.
REQ-011 States SHALL be IDLE, XFER and GAP; reset state is IDLE.
REQ-012 IDLE: when at least one sN_axis_tvalid is high, the winner is registered into grant and the state moves to XFER on the next edge; no beat is transferred in the IDLE cycle (one-cycle arbitration latency).
REQ-013 Arbitration SHALL be round-robin: when both requesters are valid, the port not granted last wins; a single valid requester always wins.
REQ-014 The last-granted record SHALL reset to port 1, so port 0 wins the first tie after reset.
REQ-015 XFER: m_axis_tdata, m_axis_tlast and m_axis_tvalid SHALL be combinational copies of the granted port; the granted port's tready SHALL equal m_axis_tready; zero-cycle data latency.
REQ-016 The non-granted port's tready SHALL be 0 in every state; both treadys and m_axis_tvalid SHALL be 0 in IDLE and GAP.
REQ-017 A beat transfers only when m_axis_tvalid and m_axis_tready are both 1; the granted source SHALL not be dropped or duplicated under backpressure.
REQ-018 On a transferred beat with tlast=1 in XFER: the owner's frame counter increments by 1, wrapping 16'hFFFF to 0; grant clears to 00; state moves to GAP if IDLE_GAP>0, otherwise to IDLE.
REQ-019 GAP: a 4-bit counter SHALL hold the state for exactly IDLE_GAP cycles, then move to IDLE; requests arriving in GAP wait.
REQ-020 Minimum spacing between the last beat of one frame and the first beat of the next SHALL therefore be IDLE_GAP+1 idle cycles on the master port.
REQ-021 A requester that deasserts tvalid mid-frame SHALL keep the grant; the block never preempts a frame.
REQ-022 Payload bytes SHALL not be inspected or modified; escaping stays in the encoder.

Reset
REQ-023 While areset=1 at an edge: state=IDLE, grant=00, last-granted=port 1, gap counter=0, frame_cnt0=frame_cnt1=0.
REQ-024 During reset and in the cycle after, m_axis_tvalid, m_axis_tlast, s0_axis_tready and s1_axis_tready SHALL be 0, and m_axis_tdata SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame without emitting tlast; the next frame after reset starts with fresh arbitration.

Verification
REQ-026 Port 0 frame D5,11,22,33(tlast), m_axis_tready=1 -> master carries the same 4 bytes on consecutive cycles, tlast on 33, frame_cnt0=1, grant 01 then 00.
REQ-027 Both ports raise tvalid in the same cycle after reset, 2-byte frames each, IDLE_GAP=2 -> port 0 frame first, then 3 idle master cycles, then port 1 frame; grant 01, 00, 10.
REQ-028 Port 0 frame in progress, port 1 valid from its second beat -> port 1 tready stays 0 until port 0 tlast transfers; no interleaving on the master.
REQ-029 m_axis_tready=0 for 3 cycles mid-frame with port 0 byte E5 held -> E5 stays on m_axis_tdata, transferred exactly once, no counter change until tlast.
REQ-030 areset pulsed for one cycle in the middle of a port 1 frame -> grant=00, frame_cnt1 unchanged at 0, all valids/readys 0; next port 0 request is granted after the one-cycle arbitration latency.
REQ-031 65536 one-byte tlast frames on port 0 -> frame_cnt0 wraps to 0, frame_cnt1 remains 0.

Source files
------------

// File: rtl/manchester_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// manchester_frame_arbiter_if
//   One byte-lane frame stream (tdata/tvalid/tready/tlast).
//   master : drives tdata, tvalid, tlast; receives tready
//   slave  : receives tdata, tvalid, tlast; drives tready
// ---------------------------------------------------------------------------
interface manchester_frame_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/manchester_frame_arbiter.sv
// ---------------------------------------------------------------------------
// manchester_frame_arbiter
//   Shares one downstream Manchester escape encoder between two frame
//   requesters. Ownership is granted per frame (first beat through tlast),
//   round-robin on ties, with IDLE_GAP enforced idle cycles after each frame.
//
// Ports
//   aclk        clock, all state on rising edge
//   areset      synchronous active-high reset
//   s0_axis     requester 0 frame stream (slave)
//   s1_axis     requester 1 frame stream (slave)
//   m_axis      stream to the encoder (master)
//   grant       one-hot owner: 01 port 0, 10 port 1, 00 none
//   frame_cnt0  completed frames from port 0 (wraps)
//   frame_cnt1  completed frames from port 1 (wraps)
// ---------------------------------------------------------------------------
module manchester_frame_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int IDLE_GAP   = 2
) (
    input  logic                              aclk,
    input  logic                              areset,
    manchester_frame_arbiter_if.slave         s0_axis,
    manchester_frame_arbiter_if.slave         s1_axis,
    manchester_frame_arbiter_if.master        m_axis,
    output logic [1:0]                        grant,
    output logic [15:0]                       frame_cnt0,
    output logic [15:0]                       frame_cnt1
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    // Final GAP cycle; unused when IDLE_GAP is 0 since GAP is then skipped.
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_q, last_d;      // 1: port 1 was granted last
    logic [3:0]            gap_q, gap_d;
    logic [15:0]           cnt0_q, cnt0_d;
    logic [15:0]           cnt1_q, cnt1_d;

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  sel_tvalid;
    logic                  sel_tlast;
    logic                  beat;
    logic                  pick1;
    logic                  xfer_act;

    // Source selected by the current owner; meaningful only in XFER.
    always_comb begin
        sel_tdata  = grant_q[1] ? s1_axis.tdata  : s0_axis.tdata;
        sel_tvalid = grant_q[1] ? s1_axis.tvalid : s0_axis.tvalid;
        sel_tlast  = grant_q[1] ? s1_axis.tlast  : s0_axis.tlast;
    end

    // Outputs are forced quiet while reset is asserted so that a frame cut
    // by reset never shows a transfer or a tlast on the reset cycle.
    assign xfer_act = (state_q == XFER) && !areset;
    assign beat     = (state_q == XFER) && sel_tvalid && m_axis.tready;

    always_comb begin
        m_axis.tvalid  = 1'b0;
        m_axis.tlast   = 1'b0;
        m_axis.tdata   = '0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
        if (xfer_act) begin
            m_axis.tvalid  = sel_tvalid;
            m_axis.tlast   = sel_tlast;
            m_axis.tdata   = sel_tdata;
            s0_axis.tready = grant_q[0] & m_axis.tready;
            s1_axis.tready = grant_q[1] & m_axis.tready;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        pick1   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s0_axis.tvalid || s1_axis.tvalid) begin
                    // On a tie the port not served last wins.
                    pick1   = (s0_axis.tvalid && s1_axis.tvalid) ? !last_q : s1_axis.tvalid;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat && sel_tlast) begin
                    if (grant_q[0]) cnt0_d = cnt0_q + 16'd1;
                    if (grant_q[1]) cnt1_d = cnt1_q + 16'd1;
                    grant_d = 2'b00;
                    gap_d   = '0;
                    state_d = (IDLE_GAP > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            gap_q   <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign grant      = grant_q;
    assign frame_cnt0 = cnt0_q;
    assign frame_cnt1 = cnt1_q;

endmodule

// File: tb/tb_manchester_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_manchester_frame_arbiter
//   Self-checking bench for manchester_frame_arbiter. A transaction-level
//   reference (owner, earliest arbitration cycle, last winner, per-port frame
//   counts) predicts grant, master/slave handshake outputs and counters every
//   cycle; directed frames and randomized traffic drive the main instance.
//   A second instance with IDLE_GAP=0 runs 65536 one-byte frames for wrap.
// ---------------------------------------------------------------------------
module tb_manchester_frame_arbiter;

    localparam int BENCH_GAP = 2;

    typedef struct {
        int         cyc;
        int         port;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        aclk;
    logic        areset;
    logic        wreset;
    logic [1:0]  grant, wgrant;
    logic [15:0] frame_cnt0, frame_cnt1, wcnt0, wcnt1;

    manchester_frame_arbiter_if #(.DATA_WIDTH(8)) s0_if ();
    manchester_frame_arbiter_if #(.DATA_WIDTH(8)) s1_if ();
    manchester_frame_arbiter_if #(.DATA_WIDTH(8)) m_if ();
    manchester_frame_arbiter_if #(.DATA_WIDTH(8)) w0_if ();
    manchester_frame_arbiter_if #(.DATA_WIDTH(8)) w1_if ();
    manchester_frame_arbiter_if #(.DATA_WIDTH(8)) wm_if ();

    manchester_frame_arbiter #(.DATA_WIDTH(8), .IDLE_GAP(BENCH_GAP)) u_dut (
        .aclk       (aclk),
        .areset     (areset),
        .s0_axis    (s0_if),
        .s1_axis    (s1_if),
        .m_axis     (m_if),
        .grant      (grant),
        .frame_cnt0 (frame_cnt0),
        .frame_cnt1 (frame_cnt1)
    );

    manchester_frame_arbiter #(.DATA_WIDTH(8), .IDLE_GAP(0)) u_wrap (
        .aclk       (aclk),
        .areset     (wreset),
        .s0_axis    (w0_if),
        .s1_axis    (w1_if),
        .m_axis     (wm_if),
        .grant      (wgrant),
        .frame_cnt0 (wcnt0),
        .frame_cnt1 (wcnt1)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    beat_t       beats[$];
    int unsigned vprob = 100;
    int unsigned rprob = 100;
    logic        hs0 = 1'b0;
    logic        hs1 = 1'b0;
    logic        mon_en = 1'b0;
    logic        wrap_done = 1'b0;

    // Reference model state.
    int          cyc = 0;
    int          owner = -1;
    int          last_win = 1;
    int          arb_ok = 0;
    logic [15:0] fc0 = '0;
    logic [15:0] fc1 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-cycle reference check, sampled mid-cycle when everything is stable.
    logic        v[2], l[2];
    logic [7:0]  d[2];
    logic [11:0] exp_port;
    logic [1:0]  exp_g;
    int          win;

    always @(negedge aclk) begin
        hs0 = s0_if.tvalid && s0_if.tready;
        hs1 = s1_if.tvalid && s1_if.tready;
        if (mon_en) begin
            cyc++;
            if (areset) begin
                chk("rst_out", 32'({m_if.tvalid, m_if.tlast, m_if.tdata, s0_if.tready, s1_if.tready}), 32'd0);
                owner    = -1;
                last_win = 1;
                arb_ok   = cyc + 1;
                fc0      = '0;
                fc1      = '0;
            end else begin
                v[0] = s0_if.tvalid; l[0] = s0_if.tlast; d[0] = s0_if.tdata;
                v[1] = s1_if.tvalid; l[1] = s1_if.tlast; d[1] = s1_if.tdata;
                exp_g = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
                chk("grant", 32'(grant), 32'(exp_g));
                chk("cnt0", 32'(frame_cnt0), 32'(fc0));
                chk("cnt1", 32'(frame_cnt1), 32'(fc1));
                if (owner < 0)
                    exp_port = '0;
                else
                    exp_port = {v[owner], l[owner], d[owner],
                                (owner == 0) && m_if.tready, (owner == 1) && m_if.tready};
                chk("port", 32'({m_if.tvalid, m_if.tlast, m_if.tdata, s0_if.tready, s1_if.tready}),
                    32'(exp_port));
                if (m_if.tvalid && m_if.tready)
                    beats.push_back('{cyc, int'(grant[1]), m_if.tdata, m_if.tlast});
                if (owner >= 0) begin
                    if (v[owner] && m_if.tready && l[owner]) begin
                        if (owner == 0) fc0 = fc0 + 16'd1;
                        else            fc1 = fc1 + 16'd1;
                        owner  = -1;
                        arb_ok = cyc + BENCH_GAP + 1;
                    end
                end else if (cyc >= arb_ok && (v[0] || v[1])) begin
                    win      = (v[0] && v[1]) ? 1 - last_win : (v[1] ? 1 : 0);
                    owner    = win;
                    last_win = win;
                end
            end
        end
    end

    task automatic drive();
        s0_if.tvalid = (q0.size() > 0) && ($urandom_range(99) < vprob);
        s0_if.tdata  = (q0.size() > 0) ? q0[0][7:0] : 8'($urandom);
        s0_if.tlast  = (q0.size() > 0) ? q0[0][8] : 1'b0;
        s1_if.tvalid = (q1.size() > 0) && ($urandom_range(99) < vprob);
        s1_if.tdata  = (q1.size() > 0) ? q1[0][7:0] : 8'($urandom);
        s1_if.tlast  = (q1.size() > 0) ? q1[0][8] : 1'b0;
        m_if.tready  = ($urandom_range(99) < rprob);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
            if (hs0 && q0.size() > 0) void'(q0.pop_front());
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            drive();
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step(1);
        areset = 1'b0;
    endtask

    task automatic gen_frames(input int nframes);
        int len, p;
        logic [8:0] e;
        for (int f = 0; f < nframes; f++) begin
            len = int'($urandom_range(4, 1));
            p   = int'($urandom_range(1, 0));
            for (int b = 0; b < len; b++) begin
                e = {(b == len - 1), 8'($urandom)};
                if (p == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    initial begin
        int g;
        int e5_seen;
        areset = 1'b1;
        s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
        m_if.tready  = 1'b1;
        @(posedge aclk);
        #1;
        mon_en = 1'b1;
        do_reset();
        #1;
        chk("rst_state", 32'({grant, frame_cnt0, frame_cnt1}), 32'd0);
        chk("rst_idle", 32'({m_if.tvalid, m_if.tlast, m_if.tdata, s0_if.tready, s1_if.tready}), 32'd0);

        // Single port-0 frame, full throughput.
        beats.delete();
        q0.push_back(9'h0D5); q0.push_back(9'h011); q0.push_back(9'h022); q0.push_back(9'h133);
        step(10);
        chk("t26_n", 32'(beats.size()), 32'd4);
        if (beats.size() >= 4) begin
            chk("t26_b0", 32'(beats[0].data), 32'h0D5);
            chk("t26_b1", 32'(beats[1].data), 32'h011);
            chk("t26_b2", 32'(beats[2].data), 32'h022);
            chk("t26_b3", 32'({beats[3].last, beats[3].data}), 32'h133);
            chk("t26_consec", 32'(beats[3].cyc - beats[0].cyc), 32'd3);
        end
        chk("t26_cnt0", 32'(frame_cnt0), 32'd1);

        // Simultaneous requests after reset: port 0 first, then 3 idle cycles.
        do_reset();
        beats.delete();
        q0.push_back(9'h0A0); q0.push_back(9'h1A1);
        q1.push_back(9'h0B0); q1.push_back(9'h1B1);
        step(12);
        chk("t27_n", 32'(beats.size()), 32'd4);
        if (beats.size() >= 4) begin
            chk("t27_order", 32'({beats[0].port[0], beats[1].port[0], beats[2].port[0], beats[3].port[0]}), 32'b0011);
            chk("t27_idle", 32'(beats[2].cyc - beats[1].cyc - 1), 32'd3);
            chk("t27_data", 32'({beats[0].data, beats[1].data, beats[2].data, beats[3].data}), 32'hA0A1B0B1);
        end

        // Port 1 raises valid during port 0's frame; no interleave.
        do_reset();
        beats.delete();
        q0.push_back(9'h001); q0.push_back(9'h002); q0.push_back(9'h003); q0.push_back(9'h104);
        step(2);
        q1.push_back(9'h011); q1.push_back(9'h112);
        step(14);
        chk("t28_n", 32'(beats.size()), 32'd6);
        for (int i = 0; i < beats.size(); i++)
            chk("t28_port", 32'(beats[i].port), (i < 4) ? 32'd0 : 32'd1);

        // Backpressure holds E5 for 3 cycles, transferred once.
        do_reset();
        beats.delete();
        q0.push_back(9'h010); q0.push_back(9'h0E5); q0.push_back(9'h120);
        step(2);
        rprob = 0;
        repeat (3) begin
            step(1);
            #1;
            chk("t29_hold", 32'({m_if.tvalid, m_if.tdata}), 32'h1E5);
            chk("t29_cnt", 32'(frame_cnt0), 32'd0);
        end
        rprob = 100;
        step(6);
        e5_seen = 0;
        foreach (beats[i]) if (beats[i].data == 8'hE5) e5_seen++;
        chk("t29_n", 32'(beats.size()), 32'd3);
        chk("t29_once", 32'(e5_seen), 32'd1);
        chk("t29_cnt_end", 32'(frame_cnt0), 32'd1);

        // Reset in the middle of a port 1 frame.
        do_reset();
        beats.delete();
        q1.push_back(9'h0C0); q1.push_back(9'h0C1); q1.push_back(9'h0C2); q1.push_back(9'h1C3);
        step(3);
        areset = 1'b1;
        q1.delete();
        q0.push_back(9'h1D0);
        step(1);
        areset = 1'b0;
        #1;
        chk("t30_after", 32'({grant, frame_cnt1, m_if.tvalid, m_if.tlast, s0_if.tready, s1_if.tready}), 32'd0);
        step(6);
        chk("t30_cnt1", 32'(frame_cnt1), 32'd0);
        chk("t30_n", 32'(beats.size()), 32'd2);
        if (beats.size() >= 2)
            chk("t30_next", 32'({beats[1].port[0], beats[1].last, beats[1].data}), 32'h0_1D0);

        // Randomized traffic with backpressure, valid gaps and rare resets.
        do_reset();
        vprob = 70;
        rprob = 75;
        gen_frames(40);
        g = 0;
        while ((q0.size() > 0 || q1.size() > 0) && g < 4000) begin
            if ($urandom_range(599) == 0) begin
                areset = 1'b1;
                step(1);
                areset = 1'b0;
            end else begin
                step(1);
            end
            g++;
        end
        chk("rnd_drain", 32'(q0.size() + q1.size()), 32'd0);
        vprob = 100;
        rprob = 100;
        step(6);

        g = 0;
        while (!wrap_done && g < 150000) begin
            @(posedge aclk);
            g++;
        end
        chk("wrap_finish", 32'(wrap_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Counter wrap on a zero-gap instance: one frame every two cycles.
    initial begin
        int wcnt;
        int g;
        wreset = 1'b1;
        w0_if.tvalid = 1'b0; w0_if.tlast = 1'b1; w0_if.tdata = 8'h5A;
        w1_if.tvalid = 1'b0; w1_if.tlast = 1'b0; w1_if.tdata = 8'h00;
        wm_if.tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        wreset = 1'b0;
        w0_if.tvalid = 1'b1;
        wcnt = 0;
        g = 0;
        while (wcnt < 65536 && g < 140000) begin
            @(negedge aclk);
            g++;
            if (w0_if.tvalid && w0_if.tready) begin
                wcnt++;
                if (wcnt[11:0] == 12'd0 || wcnt < 4)
                    chk("wrap_beat", 32'({w1_if.tready, wm_if.tvalid, wm_if.tlast, wm_if.tdata}), 32'h35A);
                if (wcnt == 65535) begin
                    @(posedge aclk);
                    #1;
                    chk("wrap_ffff", 32'(wcnt0), 32'h0000FFFF);
                end
            end
        end
        chk("wrap_frames", 32'(wcnt), 32'd65536);
        @(posedge aclk);
        #1;
        chk("wrap_zero", 32'(wcnt0), 32'd0);
        chk("wrap_cnt1", 32'(wcnt1), 32'd0);
        chk("wrap_grant", 32'(wgrant), 32'd0);
        w0_if.tvalid = 1'b0;
        wrap_done = 1'b1;
    end

endmodule
